// File: rtl/ldm_rx_capture.sv
// ldm_rx_capture: oversampling receiver for the LDM scan bus, rebuilding
// each 16-row scan into a 256-bit frame with valid/sequence-error pulses.
module ldm_rx_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         LDM_CLK,
    input  logic         LDM_ADDR_EN,
    input  logic [3:0]   LDM_ADDR,
    input  logic [0:15]  LDM_LINE_DATA,
    output logic [0:255] FRAME_DATA_256,
    output logic         FRAME_VALID,
    output logic         SEQ_ERR,
    output logic         BUSY,
    output logic [3:0]   ROW_PTR,
    output logic [7:0]   FRAME_CNT
);
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t state_q, state_n;
    logic [21:0] sync_q [SYNC_STAGES];
    logic [21:0] s;
    logic clk_d, strobe, store, done, err;
    logic [3:0] addr, ptr_n;
    logic [0:15] row;
    logic [15:0] tcnt_q, tcnt_n;
    logic [0:255] row_buf;
    // All bus signals share one chain so strobe, address and data stay aligned
    assign s = sync_q[SYNC_STAGES-1];
    assign strobe = s[21] & ~clk_d & s[20];
    assign addr = s[19:16];
    assign row = s[15:0];
    assign BUSY = state_q == COLLECT;
    always_comb begin
        state_n = state_q;
        ptr_n = ROW_PTR;
        tcnt_n = tcnt_q;
        store = 1'b0;
        done = 1'b0;
        err = 1'b0;
        if (state_q == IDLE) begin
            if (strobe && addr == 4'd0) begin
                store = 1'b1;
                ptr_n = 4'd1;
                tcnt_n = '0;
                state_n = COLLECT;
            end
        end else if (strobe) begin
            tcnt_n = '0;
            if (addr == 4'd0) begin
                store = 1'b1;
                ptr_n = 4'd1;
            end else if (addr == ROW_PTR) begin
                store = 1'b1;
                done = addr == 4'd15;
                ptr_n = done ? 4'd0 : ROW_PTR + 4'd1;
                state_n = done ? IDLE : COLLECT;
            end else begin
                err = 1'b1;
                ptr_n = 4'd0;
                state_n = IDLE;
            end
        end else if (tcnt_q == 16'(TIMEOUT_CYC - 1)) begin
            err = 1'b1;
            ptr_n = 4'd0;
            tcnt_n = '0;
            state_n = IDLE;
        end else begin
            tcnt_n = tcnt_q + 16'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            clk_d <= 1'b0;
            state_q <= IDLE;
            ROW_PTR <= '0;
            tcnt_q <= '0;
            row_buf <= '0;
            FRAME_DATA_256 <= '0;
            FRAME_VALID <= 1'b0;
            SEQ_ERR <= 1'b0;
            FRAME_CNT <= '0;
        end else begin
            sync_q[0] <= {LDM_CLK, LDM_ADDR_EN, LDM_ADDR, LDM_LINE_DATA};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            clk_d <= s[21];
            state_q <= state_n;
            ROW_PTR <= ptr_n;
            tcnt_q <= tcnt_n;
            if (store) row_buf[{addr, 4'd0} +: 16] <= row;
            // Row 15 bypasses the buffer so the frame is published on the same edge
            if (done) FRAME_DATA_256 <= {row_buf[0:239], row};
            FRAME_VALID <= done;
            SEQ_ERR <= err;
            FRAME_CNT <= FRAME_CNT + 8'(done);
        end
    end
endmodule

// File: tb/tb_ldm_rx_capture.sv
// tb_ldm_rx_capture: randomized bench with a transaction-level scan-bus model.
module tb_ldm_rx_capture;
    localparam int S = 2;
    localparam int T = 32;
    logic clk = 1'b0, rstn = 1'b0, LDM_CLK = 1'b0, LDM_ADDR_EN = 1'b0;
    logic [3:0] LDM_ADDR = '0;
    logic [0:15] LDM_LINE_DATA = '0;
    logic [0:255] FRAME_DATA_256;
    logic FRAME_VALID, SEQ_ERR, BUSY;
    logic [3:0] ROW_PTR;
    logic [7:0] FRAME_CNT;

    always #5 clk = ~clk;

    ldm_rx_capture #(.SYNC_STAGES(S), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rstn(rstn), .LDM_CLK(LDM_CLK), .LDM_ADDR_EN(LDM_ADDR_EN),
        .LDM_ADDR(LDM_ADDR), .LDM_LINE_DATA(LDM_LINE_DATA),
        .FRAME_DATA_256(FRAME_DATA_256), .FRAME_VALID(FRAME_VALID), .SEQ_ERR(SEQ_ERR),
        .BUSY(BUSY), .ROW_PTR(ROW_PTR), .FRAME_CNT(FRAME_CNT)
    );

    int cyc = 0, fv_n = 0, se_n = 0, fv_cyc = 0, se_cyc = 0;
    bit both = 1'b0;
    always @(posedge clk) begin
        cyc++;
        #1;
        if (FRAME_VALID === 1'b1) begin fv_n++; fv_cyc = cyc; end
        if (SEQ_ERR === 1'b1) begin se_n++; se_cyc = cyc; end
        if (FRAME_VALID === 1'b1 && SEQ_ERR === 1'b1) both = 1'b1;
    end

    // Reference model: one call per bus row, applying the frame-assembly rules
    logic [0:15] m_rows [16];
    logic [0:255] m_frame = '0;
    int m_next = 0, m_cnt = 0, m_fv = 0, m_se = 0, last_rise = 0;
    bit m_collect = 1'b0;
    int chk = 0, pass = 0;

    function automatic void model_row(int a, logic [0:15] d, bit en);
        if (!en) return;
        if (a == 0) begin
            m_rows[0] = d;
            m_next = 1;
            m_collect = 1'b1;
        end else if (!m_collect) begin
            return;
        end else if (a == m_next) begin
            m_rows[a] = d;
            m_next++;
            if (a == 15) begin
                for (int r = 0; r < 16; r++) m_frame[16*r +: 16] = m_rows[r];
                m_cnt = (m_cnt + 1) % 256;
                m_fv++;
                m_next = 0;
                m_collect = 1'b0;
            end
        end else begin
            m_se++;
            m_next = 0;
            m_collect = 1'b0;
        end
    endfunction

    task automatic send_row(input int a, input logic [0:15] d, input bit en);
        @(negedge clk);
        LDM_ADDR = 4'(a);
        LDM_LINE_DATA = d;
        LDM_ADDR_EN = en;
        LDM_CLK = 1'b1;
        last_rise = cyc;
        repeat (4) @(negedge clk);
        LDM_CLK = 1'b0;
        repeat (3) @(negedge clk);
        model_row(a, d, en);
    endtask

    task automatic send_frame();
        for (int r = 0; r < 16; r++) send_row(r, 16'($urandom), 1'b1);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk); LDM_ADDR_EN = 1'b1; LDM_CLK = 1'b1;
        @(negedge clk); LDM_CLK = 1'b0;
        chk++; if (FRAME_DATA_256 !== '0) $display("FAIL reset_data got %h want 0", FRAME_DATA_256); else pass++;
        chk++; if (FRAME_VALID !== 1'b0) $display("FAIL reset_fv got %b want 0", FRAME_VALID); else pass++;
        chk++; if (SEQ_ERR !== 1'b0) $display("FAIL reset_se got %b want 0", SEQ_ERR); else pass++;
        chk++; if (BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", BUSY); else pass++;
        chk++; if (ROW_PTR !== 4'd0) $display("FAIL reset_ptr got %0d want 0", ROW_PTR); else pass++;
        chk++; if (FRAME_CNT !== 8'd0) $display("FAIL reset_cnt got %0d want 0", FRAME_CNT); else pass++;
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        chk++; if (fv_n + se_n !== 0) $display("FAIL reset_pulses got %0d want 0", fv_n + se_n); else pass++;
    endtask

    task automatic test_full_frame();
        logic [0:255] pat;
        int fv0;
        pat = 256'hffff_7fff_3fff_1fff_0fff_07ff_03ff_01ff_00ff_007f_003f_001f_000f_0007_0003_0001;
        fv0 = fv_n;
        for (int r = 0; r < 16; r++) send_row(r, pat[16*r +: 16], 1'b1);
        chk++; if (FRAME_DATA_256 !== pat) $display("FAIL full_data got %h want %h", FRAME_DATA_256, pat); else pass++;
        chk++; if (fv_n - fv0 !== 1) $display("FAIL full_fv_count got %0d want 1", fv_n - fv0); else pass++;
        chk++; if (fv_cyc !== last_rise + 1 + S) $display("FAIL full_latency got %0d want %0d", fv_cyc, last_rise + 1 + S); else pass++;
        chk++; if (FRAME_CNT !== 8'd1) $display("FAIL full_cnt got %0d want 1", FRAME_CNT); else pass++;
        chk++; if (ROW_PTR !== 4'd0) $display("FAIL full_ptr got %0d want 0", ROW_PTR); else pass++;
        chk++; if (BUSY !== 1'b0) $display("FAIL full_busy got %b want 0", BUSY); else pass++;
    endtask

    task automatic test_seq_err();
        send_row(0, 16'($urandom), 1'b1);
        send_row(1, 16'($urandom), 1'b1);
        chk++; if (BUSY !== 1'b1) $display("FAIL seq_busy_mid got %b want 1", BUSY); else pass++;
        send_row(3, 16'($urandom), 1'b1);
        chk++; if (se_n !== m_se) $display("FAIL seq_err_count got %0d want %0d", se_n, m_se); else pass++;
        chk++; if (BUSY !== 1'b0) $display("FAIL seq_busy_after got %b want 0", BUSY); else pass++;
        chk++; if (ROW_PTR !== 4'd0) $display("FAIL seq_ptr got %0d want 0", ROW_PTR); else pass++;
        send_frame();
        chk++; if (fv_n !== m_fv) $display("FAIL seq_fv got %0d want %0d", fv_n, m_fv); else pass++;
        chk++; if (FRAME_DATA_256 !== m_frame) $display("FAIL seq_data got %h want %h", FRAME_DATA_256, m_frame); else pass++;
    endtask

    task automatic test_restart();
        int fv0, se0;
        fv0 = fv_n;
        se0 = se_n;
        for (int r = 0; r < 6; r++) send_row(r, 16'($urandom), 1'b1);
        chk++; if (ROW_PTR !== 4'd6) $display("FAIL restart_ptr got %0d want 6", ROW_PTR); else pass++;
        send_frame();
        chk++; if (fv_n - fv0 !== 1) $display("FAIL restart_fv got %0d want 1", fv_n - fv0); else pass++;
        chk++; if (se_n !== se0) $display("FAIL restart_se got %0d want %0d", se_n, se0); else pass++;
        chk++; if (FRAME_DATA_256 !== m_frame) $display("FAIL restart_data got %h want %h", FRAME_DATA_256, m_frame); else pass++;
        chk++; if (FRAME_CNT !== 8'(m_cnt)) $display("FAIL restart_cnt got %0d want %0d", FRAME_CNT, m_cnt); else pass++;
    endtask

    task automatic test_ignore();
        int se0;
        se0 = se_n;
        send_row(0, 16'($urandom), 1'b0);
        chk++; if (BUSY !== 1'b0) $display("FAIL ignore_en_busy got %b want 0", BUSY); else pass++;
        repeat (3) send_row(7, 16'($urandom), 1'b1);
        chk++; if (BUSY !== 1'b0) $display("FAIL ignore_idle_busy got %b want 0", BUSY); else pass++;
        chk++; if (ROW_PTR !== 4'd0) $display("FAIL ignore_ptr got %0d want 0", ROW_PTR); else pass++;
        chk++; if (se_n !== se0) $display("FAIL ignore_se got %0d want %0d", se_n, se0); else pass++;
    endtask

    task automatic test_random();
        bit prev_en, en;
        int a, r;
        prev_en = 1'b1;
        repeat (200) begin
            en = prev_en ? ($urandom_range(0, 9) != 0) : 1'b1;
            r = $urandom_range(0, 19);
            a = r < 17 ? m_next : (r == 17 ? 0 : $urandom_range(0, 15));
            send_row(a, 16'($urandom), en);
            prev_en = en;
        end
        chk++; if (fv_n !== m_fv) $display("FAIL rand_fv got %0d want %0d", fv_n, m_fv); else pass++;
        chk++; if (se_n !== m_se) $display("FAIL rand_se got %0d want %0d", se_n, m_se); else pass++;
        chk++; if (FRAME_DATA_256 !== m_frame) $display("FAIL rand_data got %h want %h", FRAME_DATA_256, m_frame); else pass++;
        chk++; if (FRAME_CNT !== 8'(m_cnt)) $display("FAIL rand_cnt got %0d want %0d", FRAME_CNT, m_cnt); else pass++;
        chk++; if (ROW_PTR !== 4'(m_next)) $display("FAIL rand_ptr got %0d want %0d", ROW_PTR, m_next); else pass++;
        chk++; if (BUSY !== m_collect) $display("FAIL rand_busy got %b want %b", BUSY, m_collect); else pass++;
        repeat (T + 8) @(negedge clk);
        if (m_collect) begin m_se++; m_collect = 1'b0; m_next = 0; end
        chk++; if (se_n !== m_se) $display("FAIL rand_drain_se got %0d want %0d", se_n, m_se); else pass++;
    endtask

    task automatic test_timeout();
        int se0, rise, n;
        se0 = se_n;
        send_row(0, 16'($urandom), 1'b1);
        rise = last_rise;
        n = 0;
        while (se_n == se0 && n < 3 * T) begin @(negedge clk); n++; end
        m_se++; m_collect = 1'b0; m_next = 0;
        chk++; if (se_n !== m_se) $display("FAIL timeout_seen got %0d want %0d", se_n, m_se); else pass++;
        chk++; if (se_cyc !== rise + 1 + S + T) $display("FAIL timeout_cycle got %0d want %0d", se_cyc, rise + 1 + S + T); else pass++;
        chk++; if (BUSY !== 1'b0) $display("FAIL timeout_busy got %b want 0", BUSY); else pass++;
    endtask

    task automatic test_reset_mid();
        int fv0, se0;
        for (int r = 0; r < 10; r++) send_row(r, 16'($urandom), 1'b1);
        fv0 = fv_n;
        se0 = se_n;
        @(negedge clk); rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        m_next = 0; m_collect = 1'b0; m_cnt = 0; m_frame = '0;
        repeat (T + 8) @(negedge clk);
        chk++; if (fv_n !== fv0 || se_n !== se0) $display("FAIL midreset_pulses got %0d/%0d want %0d/%0d", fv_n, se_n, fv0, se0); else pass++;
        chk++; if (ROW_PTR !== 4'd0) $display("FAIL midreset_ptr got %0d want 0", ROW_PTR); else pass++;
        chk++; if (FRAME_CNT !== 8'd0) $display("FAIL midreset_cnt got %0d want 0", FRAME_CNT); else pass++;
        chk++; if (FRAME_DATA_256 !== m_frame) $display("FAIL midreset_data got %h want 0", FRAME_DATA_256); else pass++;
    endtask

    task automatic test_back_to_back();
        int fv0;
        fv0 = fv_n;
        repeat (255) send_frame();
        chk++; if (FRAME_CNT !== 8'd255) $display("FAIL b2b_cnt255 got %0d want 255", FRAME_CNT); else pass++;
        send_frame();
        chk++; if (FRAME_CNT !== 8'(m_cnt)) $display("FAIL b2b_wrap got %0d want %0d", FRAME_CNT, m_cnt); else pass++;
        chk++; if (fv_n - fv0 !== 256) $display("FAIL b2b_fv got %0d want 256", fv_n - fv0); else pass++;
        chk++; if (FRAME_DATA_256 !== m_frame) $display("FAIL b2b_data got %h want %h", FRAME_DATA_256, m_frame); else pass++;
        chk++; if (both !== 1'b0) $display("FAIL exclusive_pulses got %b want 0", both); else pass++;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_seq_err();
        test_restart();
        test_ignore();
        test_random();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
